// File: rtl/bridge_pkg.sv
// Shared constants and enums for the ASCII command parser that feeds the core chain.
package bridge_pkg;

  localparam logic [7:0] CH_R_UP = 8'h52;
  localparam logic [7:0] CH_R_LO = 8'h72;
  localparam logic [7:0] CH_W_UP = 8'h57;
  localparam logic [7:0] CH_W_LO = 8'h77;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    CMD_R,
    CMD_W,
    HEX,
    EOL,
    OTHER
  } char_cls_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bridge_rx_hex_decode.sv
// Combinational byte classifier: character class, hex flag and decoded nibble.
module hex_decode
  import bridge_pkg::*;
(
  input  logic [7:0] byte_i,
  output logic [3:0] nibble_o,
  output logic       is_hex_o,
  output char_cls_e  cls_o
);

  logic is_digit;
  logic is_letter;

  always_comb begin
    is_digit  = (byte_i >= 8'h30) && (byte_i <= 8'h39);
    is_letter = ((byte_i >= 8'h41) && (byte_i <= 8'h46)) ||
                ((byte_i >= 8'h61) && (byte_i <= 8'h66));
    is_hex_o  = is_digit || is_letter;

    // 'A'/'a' have low nibble 1, so adding 9 yields 10..15 for both cases.
    nibble_o = is_letter ? (byte_i[3:0] + 4'd9) : byte_i[3:0];

    cls_o = OTHER;
    if ((byte_i == CH_R_UP) || (byte_i == CH_R_LO)) begin
      cls_o = CMD_R;
    end else if ((byte_i == CH_W_UP) || (byte_i == CH_W_LO)) begin
      cls_o = CMD_W;
    end else if (is_hex_o) begin
      cls_o = HEX;
    end else if ((byte_i == CH_CR) || (byte_i == CH_LF)) begin
      cls_o = EOL;
    end
  end

endmodule

// File: rtl/bridge_rx.sv
// Decodes "R<addr>EOL" / "W<addr><data>EOL" byte streams into single-cycle bus strobes.
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int ADDR_HEX = 4,
  parameter int DATA_HEX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [4*ADDR_HEX-1:0] addr_o,
  output logic [4*DATA_HEX-1:0] data_o,
  output logic                  rw_o,
  output logic                  valid_o,
  output logic                  err_o
);

  localparam int AW    = 4 * ADDR_HEX;
  localparam int DW    = 4 * DATA_HEX;
  localparam int CNT_W = $clog2(max_int(ADDR_HEX, DATA_HEX) + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_HEX - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_HEX - 1);

  logic [3:0] nibble;
  logic       is_hex;
  char_cls_e  cls;

  hex_decode u_hex_decode (
    .byte_i   (data_i),
    .nibble_o (nibble),
    .is_hex_o (is_hex),
    .cls_o    (cls)
  );

  state_e           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [AW-1:0]    addr_sh_q, addr_sh_d;
  logic [DW-1:0]    data_sh_q, data_sh_d;
  logic             rw_sh_q,   rw_sh_d;
  logic [AW-1:0]    addr_q,    addr_d;
  logic [DW-1:0]    data_q,    data_d;
  logic             rw_q,      rw_d;
  logic             valid_q,   valid_d;
  logic             err_q,     err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    rw_sh_d   = rw_sh_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rw_d      = rw_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (valid_i) begin
      // A command letter always (re)starts a message; a partial one is dropped silently.
      if ((cls == CMD_R) || (cls == CMD_W)) begin
        state_d   = ADDR;
        cnt_d     = '0;
        addr_sh_d = '0;
        data_sh_d = '0;
        rw_sh_d   = (cls == CMD_W);
      end else begin
        unique case (state_q)
          IDLE: begin
            if (cls != EOL) begin
              err_d = 1'b1;
            end
          end
          ADDR: begin
            if (is_hex) begin
              addr_sh_d = (addr_sh_q << 4) | AW'(nibble);
              if (cnt_q == ADDR_LAST) begin
                cnt_d   = '0;
                state_d = rw_sh_q ? DATA : DONE;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          DATA: begin
            if (is_hex) begin
              data_sh_d = (data_sh_q << 4) | DW'(nibble);
              if (cnt_q == DATA_LAST) begin
                cnt_d   = '0;
                state_d = DONE;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          DONE: begin
            if (cls == EOL) begin
              addr_d  = addr_sh_q;
              data_d  = data_sh_q;
              rw_d    = rw_sh_q;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      rw_sh_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      rw_sh_q   <= rw_sh_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rw_q      <= rw_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign rw_o    = rw_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_bridge_rx.sv
// Directed bench for bridge_rx: byte-stream commands in, strobes and decoded fields checked.
module tb_bridge_rx;

  localparam int W = 1 + 16 + 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic [15:0] addr_o;
  logic [15:0] data_o;
  logic        rw_o;
  logic        valid_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_base;
  int vld_base;

  logic [W-1:0] exp_q[$];

  bridge_rx #(.ADDR_HEX(4), .DATA_HEX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (data_i),
    .valid_i (valid_i),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .rw_o    (rw_o),
    .valid_o (valid_o),
    .err_o   (err_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every valid_o pulse must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && err_o) both_cnt++;
      if (err_o) err_cnt++;
      if (valid_o) begin
        vld_cnt++;
        chk("sb_expected_txn", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("sb_txn", {rw_o, addr_o, data_o}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data_i  = b;
    valid_i = 1'b1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  // first cycle after the last byte: valid_i drops, outputs are sampled
  task automatic end_msg();
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr_o, 16'h0000);
    chk("rst_data", data_o, 16'h0000);
    chk("rst_rw", rw_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_err", err_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // R0123\r at full rate, 1-cycle latency
    err_base = err_cnt;
    exp_q.push_back({1'b0, 16'h0123, 16'h0000});
    send_str("R0123\r", 0);
    end_msg();
    chk("t1_valid_lat", valid_o, 1);
    chk("t1_addr", addr_o, 16'h0123);
    chk("t1_data", data_o, 16'h0000);
    chk("t1_rw", rw_o, 0);
    @(negedge clk);
    chk("t1_valid_one_cycle", valid_o, 0);
    chk("t1_no_err", err_cnt - err_base, 0);
    idle(2);

    // mixed-case write with 3-cycle gaps
    err_base = err_cnt;
    exp_q.push_back({1'b1, 16'h12AB, 16'hCDEF});
    send_str("w12aB", 3);
    send_str("cdEF\n", 3);
    chk("t2_rw", rw_o, 1);
    chk("t2_addr", addr_o, 16'h12AB);
    chk("t2_data", data_o, 16'hCDEF);
    chk("t2_no_err", err_cnt - err_base, 0);

    // CRLF / LFCR pairs produce no error
    err_base = err_cnt;
    vld_base = vld_cnt;
    exp_q.push_back({1'b0, 16'h0001, 16'h0000});
    exp_q.push_back({1'b0, 16'h0002, 16'h0000});
    send_str("R0001\r\n", 0);
    send_str("R0002\n\r", 0);
    idle(3);
    chk("t3_valid_count", vld_cnt - vld_base, 2);
    chk("t3_no_err", err_cnt - err_base, 0);
    chk("t3_addr_last", addr_o, 16'h0002);

    // bad hex digit: err 1 cycle after G, another for the stray 4
    err_base = err_cnt;
    vld_base = vld_cnt;
    send_str("R12G", 0);
    @(negedge clk);
    chk("t4_err_lat", err_o, 1);
    data_i = "4";
    @(posedge clk);
    send("\r");
    idle(3);
    chk("t4_err_count", err_cnt - err_base, 2);
    chk("t4_no_valid", vld_cnt - vld_base, 0);
    chk("t4_addr_hold", addr_o, 16'h0002);
    chk("t4_rw_hold", rw_o, 0);
    chk("t4_data_hold", data_o, 16'h0000);

    // restart mid-message, then short address
    err_base = err_cnt;
    exp_q.push_back({1'b0, 16'h0005, 16'h0000});
    send_str("W12R0005\r", 0);
    idle(2);
    chk("t5_no_err", err_cnt - err_base, 0);
    chk("t5_addr", addr_o, 16'h0005);
    chk("t5_rw", rw_o, 0);
    err_base = err_cnt;
    vld_base = vld_cnt;
    send_str("R01\r", 0);
    end_msg();
    chk("t5_short_err_lat", err_o, 1);
    idle(2);
    chk("t5_short_err_count", err_cnt - err_base, 1);
    chk("t5_short_no_valid", vld_cnt - vld_base, 0);

    // reset mid-write discards it
    vld_base = vld_cnt;
    send_str("W1234", 0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("t6_rst_addr", addr_o, 16'h0000);
    chk("t6_rst_data", data_o, 16'h0000);
    chk("t6_rst_rw", rw_o, 0);
    chk("t6_rst_valid", valid_o, 0);
    chk("t6_rst_err", err_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    err_base = err_cnt;
    exp_q.push_back({1'b0, 16'h00FF, 16'h0000});
    send_str("R00FF\r", 0);
    end_msg();
    chk("t6_valid", valid_o, 1);
    chk("t6_addr", addr_o, 16'h00FF);
    chk("t6_rw", rw_o, 0);
    idle(3);
    chk("t6_single_read", vld_cnt - vld_base, 1);
    chk("t6_no_err", err_cnt - err_base, 0);

    // final report
    chk("sb_drained", exp_q.size(), 0);
    chk("never_both_strobes", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
